// File: rtl/phv_sync_fifo.sv
// First-word-fall-through PHV queue between the last match-action stage and the deparser.
// Occupancy-decoded flags, same-cycle push/pop when full, saturating drop counter and sticky error flags.
module phv_sync_fifo #(
    parameter int PHV_WIDTH  = 1124,
    parameter int DEPTH_LOG2 = 5,
    parameter int NF_THRESH  = 28,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [PHV_WIDTH-1:0]  phv_in,
    input  logic                  phv_in_valid,
    output logic [PHV_WIDTH-1:0]  phv_out,
    output logic                  phv_out_valid,
    input  logic                  phv_rd_en,
    output logic                  nearly_full,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   occupancy,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic                  overflow_sticky,
    output logic                  underflow_sticky,
    input  logic                  clr_stats
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_OCC = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] NF_OCC    = (DEPTH_LOG2 + 1)'(NF_THRESH);

    logic [PHV_WIDTH-1:0]  mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   occ_q, occ_d;
    logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic rd_acc, wr_acc, drop, underflow;

    // Every flag is a decode of registered occupancy, so none can see phv_in combinationally.
    assign full             = (occ_q == DEPTH_OCC);
    assign phv_out_valid    = (occ_q != '0);
    assign nearly_full      = (occ_q >= NF_OCC);
    assign occupancy        = occ_q;
    assign drop_cnt         = drop_cnt_q;
    assign overflow_sticky  = ovf_q;
    assign underflow_sticky = unf_q;
    assign phv_out          = mem_q[rd_ptr_q];

    assign rd_acc    = phv_rd_en & phv_out_valid;
    assign wr_acc    = phv_in_valid & (~full | rd_acc);
    assign drop      = phv_in_valid & full & ~rd_acc;
    assign underflow = phv_rd_en & ~phv_out_valid;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        drop_cnt_d = drop_cnt_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;

        if (wr_acc) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);

        case ({wr_acc, rd_acc})
            2'b10:   occ_d = occ_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   occ_d = occ_q - (DEPTH_LOG2 + 1)'(1);
            default: occ_d = occ_q;
        endcase

        // A clear wins over history but not over an event in the same cycle.
        if (clr_stats) begin
            drop_cnt_d = drop ? CNT_WIDTH'(1) : '0;
            ovf_d      = drop;
            unf_d      = underflow;
        end else begin
            if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
            ovf_d = ovf_q | drop;
            unf_d = unf_q | underflow;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= phv_in;
    end

endmodule

// File: tb/tb_phv_sync_fifo.sv
// Directed bench for phv_sync_fifo: scoreboard of expected PHVs popped by a negedge monitor,
// plus hand-computed flag/counter checks and a small-counter instance for saturation.
module tb_phv_sync_fifo;
    localparam int PW = 1124;
    localparam int DL = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic areset = 1'b1;
    always #5 clk = ~clk;

    // Main instance
    logic [PW-1:0] phv_in = '0;
    logic          phv_in_valid = 1'b0;
    logic [PW-1:0] phv_out;
    logic          phv_out_valid;
    logic          phv_rd_en = 1'b0;
    logic          nearly_full, full;
    logic [DL:0]   occupancy;
    logic [15:0]   drop_cnt;
    logic          overflow_sticky, underflow_sticky;
    logic          clr_stats = 1'b0;

    phv_sync_fifo #(.PHV_WIDTH(PW), .DEPTH_LOG2(DL), .NF_THRESH(28), .CNT_WIDTH(16)) dut (
        .clk(clk), .areset(areset),
        .phv_in(phv_in), .phv_in_valid(phv_in_valid),
        .phv_out(phv_out), .phv_out_valid(phv_out_valid), .phv_rd_en(phv_rd_en),
        .nearly_full(nearly_full), .full(full), .occupancy(occupancy),
        .drop_cnt(drop_cnt), .overflow_sticky(overflow_sticky),
        .underflow_sticky(underflow_sticky), .clr_stats(clr_stats)
    );

    // Small instance: depth 2, 2-bit drop counter
    logic [7:0] s_in = 8'h00;
    logic       s_in_valid = 1'b0;
    logic [7:0] s_out;
    logic       s_out_valid, s_rd_en = 1'b0, s_nf, s_full;
    logic [1:0] s_occ;
    logic [1:0] s_drop;
    logic       s_ovf, s_unf, s_clr = 1'b0;

    phv_sync_fifo #(.PHV_WIDTH(8), .DEPTH_LOG2(1), .NF_THRESH(1), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .areset(areset),
        .phv_in(s_in), .phv_in_valid(s_in_valid),
        .phv_out(s_out), .phv_out_valid(s_out_valid), .phv_rd_en(s_rd_en),
        .nearly_full(s_nf), .full(s_full), .occupancy(s_occ),
        .drop_cnt(s_drop), .overflow_sticky(s_ovf),
        .underflow_sticky(s_unf), .clr_stats(s_clr)
    );

    // Scoreboard state
    logic [PW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int m_occ = 0;

    function automatic logic [PW-1:0] mk(input logic [31:0] tag);
        logic [PW-1:0] v;
        v = '0;
        v[31:0] = tag;
        v[PW-1 -: 32] = ~tag;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock of main-instance stimulus; the bench model decides what the queue should hold.
    task automatic cyc(input bit wv, input logic [31:0] tag, input bit rv, input bit clr);
        bit rd_ok, wr_ok;
        rd_ok = rv && (m_occ != 0);
        wr_ok = wv && ((m_occ != DEPTH) || rd_ok);
        if (wr_ok) exp_q.push_back(mk(tag));
        if (wr_ok && !rd_ok) m_occ++;
        if (rd_ok && !wr_ok) m_occ--;
        phv_in = mk(tag);
        phv_in_valid = wv;
        phv_rd_en = rv;
        clr_stats = clr;
        tick();
        phv_in_valid = 1'b0;
        phv_rd_en = 1'b0;
        clr_stats = 1'b0;
    endtask

    // Monitor: a pop happens at the coming edge whenever rd_en meets a valid head.
    always @(negedge clk) begin
        if (!areset && phv_out_valid && phv_rd_en) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_pop: got %0h with no entry expected at %0t", phv_out[63:0], $time);
            end else begin
                logic [PW-1:0] e;
                e = exp_q.pop_front();
                if (phv_out !== e) begin
                    n_err++;
                    $display("FAIL sb_pop: got %0h expected %0h (low 64 bits) at %0t",
                             phv_out[63:0], e[63:0], $time);
                end
            end
        end
    end

    initial begin
        // Reset values
        repeat (3) tick();
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_valid", 64'(phv_out_valid), 64'd0);
        check("rst_nf", 64'(nearly_full), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_ovf", 64'(overflow_sticky), 64'd0);
        check("rst_unf", 64'(underflow_sticky), 64'd0);
        areset = 1'b0;
        tick();

        // Single write: not visible in the write cycle, visible after the edge
        phv_in = mk(32'hA5);
        phv_in_valid = 1'b1;
        exp_q.push_back(mk(32'hA5));
        m_occ = 1;
        #1;
        check("wr_cycle_valid", 64'(phv_out_valid), 64'd0);
        tick();
        phv_in_valid = 1'b0;
        check("a5_valid", 64'(phv_out_valid), 64'd1);
        check("a5_data", phv_out[63:0], mk(32'hA5) & 64'hFFFF_FFFF);
        check("a5_occ", 64'(occupancy), 64'd1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        check("a5_pop_occ", 64'(occupancy), 64'd0);
        check("a5_pop_valid", 64'(phv_out_valid), 64'd0);

        // Fill 0..31 and watch the watermark and full flag
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, 32'(i), 1'b0, 1'b0);
            check("fill_nf", 64'(nearly_full), 64'(i + 1 >= 28));
            check("fill_full", 64'(full), 64'(i + 1 == DEPTH));
        end
        check("fill_occ", 64'(occupancy), 64'd32);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
        check("drain_occ", 64'(occupancy), 64'd0);
        check("drain_nf", 64'(nearly_full), 64'd0);

        // Refill 32..63, then overflow with three drops
        for (int i = 32; i < 64; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b1, 32'(100 + k), 1'b0, 1'b0);
        check("ovf_drop", 64'(drop_cnt), 64'd3);
        check("ovf_sticky", 64'(overflow_sticky), 64'd1);
        check("ovf_occ", 64'(occupancy), 64'd32);
        check("ovf_head", phv_out[63:0], 64'd32 | (64'(~32'd32) << 32) & 64'h0);
        cyc(1'b1, 32'd200, 1'b1, 1'b0);
        check("fullrw_occ", 64'(occupancy), 64'd32);
        check("fullrw_full", 64'(full), 64'd1);
        check("fullrw_drop", 64'(drop_cnt), 64'd3);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
        check("drain2_occ", 64'(occupancy), 64'd0);
        check("drain2_unf", 64'(underflow_sticky), 64'd0);

        // Empty queue with simultaneous write and read
        cyc(1'b1, 32'h77, 1'b1, 1'b0);
        check("emptyrw_unf", 64'(underflow_sticky), 64'd1);
        check("emptyrw_occ", 64'(occupancy), 64'd1);
        check("emptyrw_valid", 64'(phv_out_valid), 64'd1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 1'b1);
        check("clr_drop", 64'(drop_cnt), 64'd0);
        check("clr_ovf", 64'(overflow_sticky), 64'd0);
        check("clr_unf", 64'(underflow_sticky), 64'd0);

        // Saturation on the 2-bit counter: 2 accepted, 5 dropped
        s_in = 8'h11;
        s_in_valid = 1'b1;
        repeat (7) tick();
        check("sat_full", 64'(s_full), 64'd1);
        check("sat_drop", 64'(s_drop), 64'd3);
        check("sat_ovf", 64'(s_ovf), 64'd1);
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        s_in_valid = 1'b0;
        check("clr_with_drop_cnt", 64'(s_drop), 64'd1);
        check("clr_with_drop_ovf", 64'(s_ovf), 64'd1);

        // Asynchronous reset mid-operation with 10 entries queued
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'(300 + i), 1'b0, 1'b0);
        check("pre_rst_occ", 64'(occupancy), 64'd10);
        #2;
        areset = 1'b1;
        #1;
        check("async_rst_valid", 64'(phv_out_valid), 64'd0);
        check("async_rst_occ", 64'(occupancy), 64'd0);
        exp_q.delete();
        m_occ = 0;
        #1;
        areset = 1'b0;
        cyc(1'b1, 32'h5A5, 1'b0, 1'b0);
        check("post_rst_occ", 64'(occupancy), 64'd1);
        check("post_rst_data", phv_out[63:0], {~32'h5A5 & 32'h0, 32'h5A5});
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        check("post_rst_empty", 64'(phv_out_valid), 64'd0);

        tick();
        check("sb_leftover", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
